// File: rtl/vec_pkg.sv
// -----------------------------------------------------------------------------
// vec_pkg
// Shared constants for the vector front end: register file geometry,
// writeback port numbering and the major opcodes that route instructions
// to the vector pipeline. Imported by the decoder, the scoreboard and the
// hazard checker so that all of them agree on sizes and port roles.
// -----------------------------------------------------------------------------
package vec_pkg;

    // Register file geometry.
    localparam int NUM_VEC    = 32;
    localparam int ADDR_WIDTH = $clog2(NUM_VEC);

    // Writeback port roles. Port index is the position in wb_valid / wb_addr.
    localparam int WB_PORTS    = 2;
    localparam int WB_PORT_ALU = 0;
    localparam int WB_PORT_LD  = 1;

    // Major opcodes that steer an instruction into the vector pipeline.
    localparam logic [6:0] OPC_OP_V     = 7'h57;
    localparam logic [6:0] OPC_LOAD_FP  = 7'h07;
    localparam logic [6:0] OPC_STORE_FP = 7'h27;

endpackage : vec_pkg

// File: rtl/vec_hazard_check.sv
// -----------------------------------------------------------------------------
// vec_hazard_check
// Purely combinational RAW/WAW check of one instruction against the
// scoreboard. A register counts as busy only if it is marked busy and is not
// being written back this cycle, so a dependent instruction can issue in the
// same cycle as its producer's writeback.
//
// Ports:
//   busy          in  NUM_VEC     registered busy bits
//   clr           in  NUM_VEC     registers being written back this cycle
//   vs1_en..vs3_en in 1           source operand used
//   vs1..vs3      in  ADDR_WIDTH  source register addresses
//   vm            in  1           0 = masked op, v0 read implicitly
//   vd_en         in  1           instruction writes vd
//   vd            in  ADDR_WIDTH  destination register
//   hazard        out 1           instruction must not issue this cycle
// -----------------------------------------------------------------------------
module vec_hazard_check
    import vec_pkg::*;
#(
    parameter int NUM_VEC    = vec_pkg::NUM_VEC,
    parameter int ADDR_WIDTH = $clog2(NUM_VEC)
) (
    input  logic [NUM_VEC-1:0]    busy,
    input  logic [NUM_VEC-1:0]    clr,
    input  logic                  vs1_en,
    input  logic                  vs2_en,
    input  logic                  vs3_en,
    input  logic [ADDR_WIDTH-1:0] vs1,
    input  logic [ADDR_WIDTH-1:0] vs2,
    input  logic [ADDR_WIDTH-1:0] vs3,
    input  logic                  vm,
    input  logic                  vd_en,
    input  logic [ADDR_WIDTH-1:0] vd,
    output logic                  hazard
);

    logic [NUM_VEC-1:0] eff_busy;

    always_comb begin
        eff_busy = busy & ~clr;
        hazard   = (vs1_en && eff_busy[vs1])
                || (vs2_en && eff_busy[vs2])
                || (vs3_en && eff_busy[vs3])
                || (!vm    && eff_busy[0])      // implicit v0 mask read
                || (vd_en  && eff_busy[vd]);    // WAW keeps writebacks in order
    end

endmodule : vec_hazard_check

// File: rtl/vec_scoreboard.sv
// -----------------------------------------------------------------------------
// vec_scoreboard
// Issue-side hazard controller between the vector decoder and the register
// file read stage. Keeps one busy bit per vector register for each in-flight
// write, holds issue on RAW/WAW hazards, clears entries on ALU/load writeback,
// supports a full flush and exports occupancy and stall statistics.
//
// Handshake: an instruction transfers on a cycle where issue_valid and
// issue_ready are both high. issue_ready is combinational from the busy bits,
// same-cycle writebacks, flush and rst; it never looks at issue_valid. While
// issue_valid is high and issue_ready low the decoder holds every issue_*
// input stable.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   issue_valid/ready   issue handshake
//   vs1_en..vs3, vm     source operands (vs3 = store data, !vm reads v0)
//   vd_en, vd           destination register
//   wb_valid, wb_addr   per-port writeback, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   flush               drop all pending writes
//   busy_vec            registered busy bits
//   busy_cnt            registered popcount of busy_vec
//   stall_cycles        saturating count of valid && !ready cycles
//   wb_err              sticky: writeback to a register that was not busy
// -----------------------------------------------------------------------------
module vec_scoreboard
    import vec_pkg::*;
#(
    parameter int NUM_VEC     = vec_pkg::NUM_VEC,
    parameter int ADDR_WIDTH  = $clog2(NUM_VEC),
    parameter int WB_PORTS    = vec_pkg::WB_PORTS,
    parameter int STALL_CNT_W = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           issue_valid,
    output logic                           issue_ready,
    input  logic                           vs1_en,
    input  logic                           vs2_en,
    input  logic                           vs3_en,
    input  logic [ADDR_WIDTH-1:0]          vs1,
    input  logic [ADDR_WIDTH-1:0]          vs2,
    input  logic [ADDR_WIDTH-1:0]          vs3,
    input  logic                           vm,
    input  logic                           vd_en,
    input  logic [ADDR_WIDTH-1:0]          vd,
    input  logic [WB_PORTS-1:0]            wb_valid,
    input  logic [WB_PORTS*ADDR_WIDTH-1:0] wb_addr,
    input  logic                           flush,
    output logic [NUM_VEC-1:0]             busy_vec,
    output logic [ADDR_WIDTH:0]            busy_cnt,
    output logic [STALL_CNT_W-1:0]         stall_cycles,
    output logic                           wb_err
);

    logic [NUM_VEC-1:0]  clr;
    logic                wb_hit_idle;
    logic                hazard;
    logic                accept;
    logic                stall;
    logic [NUM_VEC-1:0]  busy_next;
    logic [ADDR_WIDTH:0] cnt_next;

    // Decode writebacks into a per-register clear mask and flag any
    // writeback that targets a register with no pending write. Two ports
    // hitting the same register simply OR into the same bit.
    always_comb begin
        clr         = '0;
        wb_hit_idle = 1'b0;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_valid[p]) begin
                clr[wb_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
                if (!busy_vec[wb_addr[p*ADDR_WIDTH +: ADDR_WIDTH]]) begin
                    wb_hit_idle = 1'b1;
                end
            end
        end
    end

    vec_hazard_check #(
        .NUM_VEC    (NUM_VEC),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_hazard (
        .busy   (busy_vec),
        .clr    (clr),
        .vs1_en (vs1_en),
        .vs2_en (vs2_en),
        .vs3_en (vs3_en),
        .vs1    (vs1),
        .vs2    (vs2),
        .vs3    (vs3),
        .vm     (vm),
        .vd_en  (vd_en),
        .vd     (vd),
        .hazard (hazard)
    );

    assign issue_ready = !rst && !flush && !hazard;
    assign accept      = issue_valid && issue_ready;
    assign stall       = issue_valid && !issue_ready;

    // Next busy state. The set is applied after the clear so that a new
    // write to a register being written back this cycle keeps it busy.
    // Flush never accepts (issue_ready is low), so clearing everything is
    // sufficient there.
    always_comb begin
        if (flush) begin
            busy_next = '0;
        end else begin
            busy_next = busy_vec & ~clr;
            if (accept && vd_en) begin
                busy_next[vd] = 1'b1;
            end
        end
        cnt_next = '0;
        for (int r = 0; r < NUM_VEC; r++) begin
            cnt_next = cnt_next + (ADDR_WIDTH+1)'(busy_next[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_vec     <= '0;
            busy_cnt     <= '0;
            stall_cycles <= '0;
            wb_err       <= 1'b0;
        end else begin
            busy_vec <= busy_next;
            busy_cnt <= cnt_next;
            // Writebacks racing a flush are dropped silently.
            if (!flush && wb_hit_idle) begin
                wb_err <= 1'b1;
            end
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end

endmodule : vec_scoreboard

// File: tb/tb_vec_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_vec_scoreboard
// Directed bench for vec_scoreboard. Inputs change #1 after the rising edge;
// combinational issue_ready is checked #1 after driving, registered outputs
// are checked #1 after the edge that updates them.
// -----------------------------------------------------------------------------
module tb_vec_scoreboard;

    localparam int NUM_VEC     = 32;
    localparam int ADDR_WIDTH  = 5;
    localparam int WB_PORTS    = 2;
    localparam int STALL_CNT_W = 16;

    logic                           clk;
    logic                           rst;
    logic                           issue_valid;
    logic                           issue_ready;
    logic                           vs1_en, vs2_en, vs3_en;
    logic [ADDR_WIDTH-1:0]          vs1, vs2, vs3;
    logic                           vm;
    logic                           vd_en;
    logic [ADDR_WIDTH-1:0]          vd;
    logic [WB_PORTS-1:0]            wb_valid;
    logic [WB_PORTS*ADDR_WIDTH-1:0] wb_addr;
    logic                           flush;
    logic [NUM_VEC-1:0]             busy_vec;
    logic [ADDR_WIDTH:0]            busy_cnt;
    logic [STALL_CNT_W-1:0]         stall_cycles;
    logic                           wb_err;

    int checks;
    int errors;
    logic [31:0] exp_q[$];

    vec_scoreboard #(
        .NUM_VEC     (NUM_VEC),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .WB_PORTS    (WB_PORTS),
        .STALL_CNT_W (STALL_CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .vs1_en       (vs1_en),
        .vs2_en       (vs2_en),
        .vs3_en       (vs3_en),
        .vs1          (vs1),
        .vs2          (vs2),
        .vs3          (vs3),
        .vm           (vm),
        .vd_en        (vd_en),
        .vd           (vd),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .flush        (flush),
        .busy_vec     (busy_vec),
        .busy_cnt     (busy_cnt),
        .stall_cycles (stall_cycles),
        .wb_err       (wb_err)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_issue();
        issue_valid = 1'b0;
        vs1_en = 1'b0; vs2_en = 1'b0; vs3_en = 1'b0;
        vs1 = '0; vs2 = '0; vs3 = '0;
        vm = 1'b1;
        vd_en = 1'b0; vd = '0;
    endtask

    task automatic clear_wb();
        wb_valid = '0;
        wb_addr  = '0;
    endtask

    // Present one instruction; each source is enabled when its address is >= 0.
    task automatic drive_issue(input logic d_en, input int d,
                               input int s1, input int s2, input int s3,
                               input logic mask_vm);
        issue_valid = 1'b1;
        vd_en  = d_en;
        vd     = ADDR_WIDTH'(d);
        vs1_en = (s1 >= 0); vs1 = ADDR_WIDTH'((s1 >= 0) ? s1 : 0);
        vs2_en = (s2 >= 0); vs2 = ADDR_WIDTH'((s2 >= 0) ? s2 : 0);
        vs3_en = (s3 >= 0); vs3 = ADDR_WIDTH'((s3 >= 0) ? s3 : 0);
        vm     = mask_vm;
    endtask

    task automatic drive_wb(input int port, input int addr);
        wb_valid[port] = 1'b1;
        wb_addr[port*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(addr);
    endtask

    // Issue a lone write to register d and let it be accepted.
    task automatic make_busy(input int d);
        drive_issue(1'b1, d, -1, -1, -1, 1'b1);
        tick();
        clear_issue();
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [31:0] e_busy,
                               input int e_cnt);
        check({tag, " busy_vec"}, busy_vec, e_busy);
        check({tag, " busy_cnt"}, 32'(busy_cnt), 32'(e_cnt));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] exp_busy;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        flush = 1'b0;
        clear_issue();
        clear_wb();

        // Reset.
        tick();
        tick();
        check("ready during rst", 32'(issue_ready), 32'd0);
        rst = 1'b0;
        #1;
        check_state("reset", 32'h0, 0);
        check("reset stall_cycles", 32'(stall_cycles), 32'd0);
        check("reset wb_err", 32'(wb_err), 32'd0);
        check("ready after rst", 32'(issue_ready), 32'd1);

        // Single write to v3 with no sources.
        drive_issue(1'b1, 3, -1, -1, -1, 1'b1);
        #1;
        check("issue vd3 ready", 32'(issue_ready), 32'd1);
        tick();
        clear_issue();
        check_state("after vd3", 32'h8, 1);

        // RAW on vs2=v3: four stall cycles, then accepted in the writeback cycle.
        drive_issue(1'b0, 0, -1, 3, -1, 1'b1);
        #1;
        check("raw vs2 stall", 32'(issue_ready), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("stall count 4", 32'(stall_cycles), 32'd4);
        drive_wb(0, 3);
        #1;
        check("raw bypass ready", 32'(issue_ready), 32'd1);
        tick();
        clear_issue();
        clear_wb();
        check_state("after wb v3", 32'h0, 0);
        check("stall held at 4", 32'(stall_cycles), 32'd4);
        check("no wb_err", 32'(wb_err), 32'd0);

        // v0 busy: masked op stalls, unmasked op goes.
        make_busy(0);
        check_state("v0 busy", 32'h1, 1);
        drive_issue(1'b0, 0, -1, -1, -1, 1'b0);
        #1;
        check("masked v0 stall", 32'(issue_ready), 32'd0);
        tick();
        check("stall count 5", 32'(stall_cycles), 32'd5);
        vm = 1'b1;
        #1;
        check("unmasked ready", 32'(issue_ready), 32'd1);
        // vs1, vs3 and WAW hazards against v0 (no clock edge, just the comb path).
        drive_issue(1'b0, 0, 0, -1, -1, 1'b1);
        #1;
        check("vs1 hazard", 32'(issue_ready), 32'd0);
        drive_issue(1'b0, 0, -1, -1, 0, 1'b1);
        #1;
        check("vs3 hazard", 32'(issue_ready), 32'd0);
        drive_issue(1'b1, 0, -1, -1, -1, 1'b1);
        #1;
        check("waw hazard", 32'(issue_ready), 32'd0);
        issue_valid = 1'b0;
        drive_wb(1, 0);
        tick();
        clear_issue();
        clear_wb();
        check_state("load wb v0", 32'h0, 0);
        check("stall count still 5", 32'(stall_cycles), 32'd5);

        // Same-cycle writeback and new write to v5: set wins.
        make_busy(5);
        check_state("v5 busy", 32'h20, 1);
        drive_issue(1'b1, 5, -1, -1, -1, 1'b1);
        drive_wb(0, 5);
        #1;
        check("wb+issue v5 ready", 32'(issue_ready), 32'd1);
        tick();
        clear_issue();
        clear_wb();
        check_state("v5 set wins", 32'h20, 1);
        check("v5 no wb_err", 32'(wb_err), 32'd0);
        drive_wb(0, 5);
        tick();
        clear_wb();
        check_state("v5 cleared", 32'h0, 0);

        // Back-to-back independent issues, one per cycle.
        exp_busy = 32'h0;
        for (int r = 10; r <= 12; r++) begin
            exp_busy[r] = 1'b1;
            exp_q.push_back(exp_busy);
        end
        for (int r = 10; r <= 12; r++) begin
            drive_issue(1'b1, r, -1, -1, -1, 1'b1);
            #1;
            check("b2b ready", 32'(issue_ready), 32'd1);
            tick();
            check("b2b busy_vec", busy_vec, exp_q.pop_front());
        end
        clear_issue();
        check("b2b busy_cnt", 32'(busy_cnt), 32'd3);

        // Both ports retire v10 in the same cycle.
        drive_wb(0, 10);
        drive_wb(1, 10);
        tick();
        clear_wb();
        check_state("dual wb v10", 32'h1800, 2);
        check("dual wb no err", 32'(wb_err), 32'd0);
        drive_wb(0, 11);
        drive_wb(1, 12);
        tick();
        clear_wb();
        check_state("wb v11 v12", 32'h0, 0);

        // Flush with a racing writeback to an idle register and a valid issue.
        make_busy(1);
        make_busy(2);
        make_busy(7);
        check_state("v1 v2 v7 busy", 32'h86, 3);
        flush = 1'b1;
        drive_wb(0, 9);
        drive_issue(1'b1, 4, -1, -1, -1, 1'b1);
        #1;
        check("flush ready", 32'(issue_ready), 32'd0);
        tick();
        flush = 1'b0;
        clear_issue();
        clear_wb();
        check_state("after flush", 32'h0, 0);
        check("flush no wb_err", 32'(wb_err), 32'd0);
        check("flush stall", 32'(stall_cycles), 32'd6);

        // Writeback to idle v9 raises sticky wb_err.
        drive_wb(1, 9);
        tick();
        clear_wb();
        check("wb_err set", 32'(wb_err), 32'd1);
        tick();
        tick();
        check("wb_err sticky", 32'(wb_err), 32'd1);

        // Saturation: hold a RAW hazard for 70000 cycles.
        make_busy(3);
        drive_issue(1'b0, 0, 3, -1, -1, 1'b1);
        for (int i = 0; i < 70000; i++) tick();
        check("stall saturated", 32'(stall_cycles), 32'h0000_FFFF);
        check("still stalled", 32'(issue_ready), 32'd0);
        check_state("pre-rst", 32'h8, 1);

        // Reset mid-operation with the instruction still presented.
        rst = 1'b1;
        tick();
        check("ready in rst", 32'(issue_ready), 32'd0);
        check_state("mid rst", 32'h0, 0);
        check("mid rst stall", 32'(stall_cycles), 32'd0);
        check("mid rst wb_err", 32'(wb_err), 32'd0);
        rst = 1'b0;
        #1;
        check("ready after mid rst", 32'(issue_ready), 32'd1);
        tick();
        clear_issue();
        check_state("post rst issue", 32'h0, 0);
        check("post rst stall", 32'(stall_cycles), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_vec_scoreboard
